xor5_parity_sched: RTL and testbench
====================================

Name: xor5_parity_sched

Overview:
- Round-robin scheduler that shares one 5-bit XOR reduction slice (an `xor5` instance) among NUM_REQ requesters.
- Each accepted request carries a DATA_W-bit word. The block feeds it through the slice 5 bits per cycle, accumulates the even-parity result, and returns it with the requester ID on a valid/ready response port.
- Sits between parity-checking clients and the shared reduction datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 20, word width; must be a multiple of 5. Elaboration error otherwise.
- ID_W, $clog2(NUM_REQ), width of the response ID; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_parity  out  1  XOR of all DATA_W bits of the accepted word.
- rsp_id  out  ID_W  index of the requester that produced the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert): state=IDLE, rsp_valid=0, rsp_parity=0, rsp_id=0, busy=0, req_ready=0, RR pointer=0 (requester 0 highest priority). Deassertion is synchronised by the parent.
- FSM states and transitions:
  - IDLE -> RUN on accept.
  - RUN -> DONE after CHUNKS=DATA_W/5 cycles.
  - DONE -> IDLE on rsp_valid && rsp_ready.
- Arbitration (IDLE only):
  - req_ready is combinational: one-hot, the first req_valid bit found searching from the RR pointer upward with wrap.
  - All zero outside IDLE, and all zero when no request is valid.
  - Accept = req_valid[i] && req_ready[i].
  - On accept: capture the word, capture ID=i, accumulator=0, chunk counter=0, pointer=(i+1) mod NUM_REQ.
  - Requesters may drop req_valid before being granted; nothing is latched until accept.
- RUN:
  - Each cycle, bits [5k+4:5k] of the captured word go to the xor5 slice; accumulator ^= slice output; k increments.
  - After chunk CHUNKS-1, go to DONE with rsp_parity=accumulator.
- Latency: rsp_valid rises exactly CHUNKS clock edges after the accepting edge (4 for the defaults).
- DONE:
  - rsp_valid=1; rsp_parity and rsp_id held stable until handshake.
  - Handshake edge returns to IDLE with rsp_valid=0.
  - A new accept cannot occur in the handshake cycle, so back-to-back throughput is one result per CHUNKS+2 cycles.
- Counter widths:
  - Chunk counter is $clog2(CHUNKS) bits (minimum 1).
  - Counter wrap is unreachable because the FSM exits RUN first.
- Reset mid-operation: any in-flight word is discarded with no response; the requester is not re-notified.
- busy is registered from state.

Optional Feature:
Macro: XOR5_SCHED_EXPECT_EN.
- When defined:
  - Adds input req_exp[NUM_REQ]: expected parity, captured with the word.
  - Adds output rsp_err: rsp_parity != captured expectation; valid with rsp_valid; 0 at reset.
  - Adds output err_cnt[7:0]: increments on each response handshake with rsp_err=1, saturates at 255, clears only on rst.
- When undefined: these ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package xor5_sched_pkg:
  - state enum {IDLE, RUN, DONE} (2 bits).
  - CHUNK_W=5.
  - ERR_CNT_W=8.
- Sub-module xor5_rr_arb(NUM_REQ): combinational one-hot grant from valid vector plus pointer; the pointer register stays in the parent.
- The existing xor5 is instantiated as the reduction slice, not re-coded.

Test Plan:
- Lone request, requester 2, data 20'h00001, rsp_ready=1 -> req_ready=4'b0100 that cycle; rsp_valid 4 edges later; rsp_parity=1, rsp_id=2.
- Parity values: data 20'hFFFFF -> parity 0; data 20'h0001F -> parity 1; data 20'h84210 -> parity 0.
- All four req_valid held high, rsp_ready=1, 5 transactions -> grant order 0,1,2,3,0; one response per 6 cycles.
- rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_parity and rsp_id stable; req_ready=0; busy=1; accept occurs only after handshake.
- rst asserted during RUN, with requester 1 granted and chunk 2 in progress -> outputs reset immediately and no response is produced; after release, with reqs 1 and 3 valid, requester 1 is granted first (pointer=0).
- With XOR5_SCHED_EXPECT_EN: data 20'h00001 with req_exp=0 -> rsp_err=1 and err_cnt=1; 300 such errors -> err_cnt=255.

Source files
------------

// File: rtl/xor5_sched_pkg.sv
// Shared types and constants for the round-robin xor5 parity scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package xor5_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one reduction chunk fed to the shared slice each cycle.
    localparam int CHUNK_W   = 5;
    // Width of the saturating mismatch counter (expectation-check build only).
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/xor5.sv
// Shared 5-bit XOR reduction slice.
// Latency: combinational.
// Backpressure: none; output follows input.
module xor5 (
    input  logic [4:0] a,
    output logic       y
);

    assign y = ^a;

endmodule

// File: rtl/xor5_rr_arb.sv
// Round-robin one-hot grant: first valid requester at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: grants nothing while en is low or no request is valid.
module xor5_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // ptr and off are both below NUM_REQ, so one subtraction wraps.
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (en && !gnt_vld && req_valid[cand]) begin
                gnt_vld      = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/xor5_parity_sched.sv
// Round-robin scheduler sharing one xor5 slice to compute word parity per requester.
// Latency: rsp_valid rises DATA_W/5 edges after the accepting edge; one result per DATA_W/5+2 cycles.
// Backpressure: result held in DONE until rsp_ready; no new grant until the handshake completes.
// Optional build macro XOR5_SCHED_EXPECT_EN adds req_exp, rsp_err and err_cnt.
module xor5_parity_sched
    import xor5_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 20,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef XOR5_SCHED_EXPECT_EN
    input  logic [NUM_REQ-1:0]        req_exp,
    output logic                      rsp_err,
    output logic [ERR_CNT_W-1:0]      err_cnt,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_parity,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam int CHUNKS = DATA_W / CHUNK_W;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((DATA_W % CHUNK_W) != 0 || DATA_W < CHUNK_W) begin : g_bad_data_w
        $error("xor5_parity_sched: DATA_W must be a non-zero multiple of 5");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("xor5_parity_sched: NUM_REQ must be at least 2");
    end

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_parity_q, rsp_parity_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic                accept;
    logic                last_chunk;
    logic                handshake;
    logic [DATA_W-1:0]   word_sel;
    logic [CHUNK_W-1:0]  slice_in;
    logic                slice_y;

    xor5_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .en        (state_q == IDLE),
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld)
    );

    xor5 u_slice (
        .a (slice_in),
        .y (slice_y)
    );

    // Grants are suppressed while reset is held so nothing looks accepted.
    assign req_ready  = rst ? '0 : gnt_oh;
    assign accept     = gnt_vld && |(req_valid & req_ready);
    assign last_chunk = (cnt_q == CNT_W'(CHUNKS - 1));
    assign handshake  = rsp_valid_q && rsp_ready;

    // Select the granted requester's word and the current chunk of the captured word.
    always_comb begin
        word_sel = '0;
        slice_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                word_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                slice_in = word_q[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    // Next-state logic: accept in IDLE, fold one chunk per cycle in RUN, wait for handshake in DONE.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_d       = word_q;
        id_d         = id_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_parity_d = rsp_parity_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    word_d  = word_sel;
                    id_d    = gnt_idx;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_q ^ slice_y;
                if (last_chunk) begin
                    state_d      = DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_parity_d = acc_q ^ slice_y;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            word_q       <= '0;
            id_q         <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_parity_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            word_q       <= word_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_parity_q <= rsp_parity_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_parity = rsp_parity_q;
    assign rsp_id     = id_q;
    assign busy       = busy_q;

`ifdef XOR5_SCHED_EXPECT_EN
    logic                 exp_q, exp_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Capture the expectation with the word, flag a mismatch on entry to DONE, count it at handshake.
    always_comb begin
        exp_d     = exp_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;
        if (state_q == IDLE && accept) begin
            exp_d = req_exp[gnt_idx];
        end
        if (state_q == RUN && last_chunk) begin
            rsp_err_d = ((acc_q ^ slice_y) != exp_q);
        end
        if (handshake) begin
            rsp_err_d = 1'b0;
            if (rsp_err_q && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Expectation-check registers; the counter clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            exp_q     <= exp_d;
            rsp_err_q <= rsp_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rsp_err = rsp_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_xor5_parity_sched.sv
// Self-checking bench for xor5_parity_sched: vector table, round-robin, stall and reset sequences.
// Latency: n/a (bench).
// Backpressure: drives rsp_ready low in the stall sequence, high elsewhere.
module tb_xor5_parity_sched;

    localparam int NR     = 4;
    localparam int DW     = 20;
    localparam int CHUNKS = DW / 5;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_parity;
    logic [1:0]         rsp_id;
    logic               busy;
`ifdef XOR5_SCHED_EXPECT_EN
    logic [NR-1:0]      req_exp;
    logic               rsp_err;
    logic [7:0]         err_cnt;
`endif

    xor5_parity_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
`ifdef XOR5_SCHED_EXPECT_EN
        .req_exp    (req_exp),
        .rsp_err    (rsp_err),
        .err_cnt    (err_cnt),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (rsp_parity),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    typedef struct {
        int         id;
        logic [19:0] data;
        logic [3:0]  ready;
        logic        par;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic       par;
    } exp_t;

    vec_t vec[6];
    exp_t sb_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_edge = 0;
    logic prev_vld = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic slot_par(input int i);
        logic [DW-1:0] w;
        w = req_data[i*DW +: DW];
        return ^w;
    endfunction

    // Scoreboard: times rsp_valid rise against the last accept and pops on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (|(req_valid & req_ready)) acc_edge = cyc + 1;
            if (rsp_valid && !prev_vld) chk("latency", cyc - acc_edge, CHUNKS);
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_parity", 32'(rsp_parity), 32'(e.par));
                end
            end
            prev_vld = rsp_valid;
        end
    end

    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready;
                return;
            end
        end
    endtask

    task automatic wait_rsp();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!rsp_valid && i < 40);
        chk("rsp_valid_seen", 32'(rsp_valid), 1);
    endtask

    task automatic drain();
        int i = 0;
        while (sb_q.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("drain_empty", sb_q.size(), 0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [3:0] g;
        int         rr_exp[5];
        int         prev;

        vec[0] = '{id: 2, data: 20'h00001, ready: 4'b0100, par: 1'b1};
        vec[1] = '{id: 0, data: 20'hFFFFF, ready: 4'b0001, par: 1'b0};
        vec[2] = '{id: 1, data: 20'h0001F, ready: 4'b0010, par: 1'b1};
        vec[3] = '{id: 3, data: 20'h84210, ready: 4'b1000, par: 1'b0};
        vec[4] = '{id: 0, data: 20'hAAAAA, ready: 4'b0001, par: 1'b0};
        vec[5] = '{id: 3, data: 20'h12345, ready: 4'b1000, par: 1'b1};
        rr_exp = '{0, 1, 2, 3, 0};

        // Reset state, with every requester asking.
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
`ifdef XOR5_SCHED_EXPECT_EN
        req_exp   = '0;
`endif
        #2;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_parity", 32'(rsp_parity), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1;
            req_data[vec[v].id*DW +: DW] = vec[v].data;
            req_valid                    = '0;
            req_valid[vec[v].id]         = 1'b1;
            sb_q.push_back('{id: 2'(vec[v].id), par: vec[v].par});
            wait_grant(g);
            chk("vec_grant", 32'(g), 32'(vec[v].ready));
            @(posedge clk);
            #1;
            req_valid = '0;
            drain();
        end

        // All four requesting continuously: grant order 0,1,2,3,0 every CHUNKS+2 cycles.
        @(posedge clk);
        #1;
        req_data = {20'h0000F, 20'h00007, 20'h00003, 20'h00001};
        for (int t = 0; t < 5; t++) sb_q.push_back('{id: 2'(rr_exp[t]), par: slot_par(rr_exp[t])});
        req_valid = 4'b1111;
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            wait_grant(g);
            chk("rr_grant", 32'(g), 32'(1) << rr_exp[t]);
            if (t > 0) chk("rr_spacing", cyc - prev, CHUNKS + 2);
            prev = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Stall in DONE for 10 cycles with another request pending.
        @(posedge clk);
        #1;
        rsp_ready          = 1'b0;
        req_data[3*DW +: DW] = 20'h12345;
        req_valid          = 4'b1000;
        sb_q.push_back('{id: 2'd3, par: 1'b1});
        wait_grant(g);
        chk("stall_grant", 32'(g), 4'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp();
        @(posedge clk);
        #1;
        req_data[0 +: DW] = 20'h00001;
        req_valid         = 4'b0001;
        sb_q.push_back('{id: 2'd0, par: 1'b1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 1);
            chk("stall_rsp_parity", 32'(rsp_parity), 1);
            chk("stall_rsp_id", 32'(rsp_id), 3);
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_busy", 32'(busy), 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_grant", 32'(req_ready), 4'b0001);
        chk("post_hs_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Reset while requester 1's word is in chunk 2; pointer must return to 0.
        @(posedge clk);
        #1;
        req_data[1*DW +: DW] = 20'h00003;
        req_valid            = 4'b0010;
        wait_grant(g);
        chk("rst_pre_grant", 32'(g), 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst                  = 1'b1;
        req_valid            = 4'b1010;
        req_data[3*DW +: DW] = 20'h00007;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rsp_parity", 32'(rsp_parity), 0);
        chk("midrst_rsp_id", 32'(rsp_id), 0);
        chk("midrst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back('{id: 2'd1, par: 1'b0});
        sb_q.push_back('{id: 2'd3, par: 1'b1});
        wait_grant(g);
        chk("postrst_grant_first", 32'(g), 4'b0010);
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        wait_grant(g);
        chk("postrst_grant_second", 32'(g), 4'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

`ifdef XOR5_SCHED_EXPECT_EN
        // Mismatch flag and saturating error counter.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("err_cnt_reset", 32'(err_cnt), 0);
        chk("rsp_err_reset", 32'(rsp_err), 0);
        req_data[0 +: DW] = 20'h00001;
        req_exp           = '0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            req_valid = 4'b0001;
            sb_q.push_back('{id: 2'd0, par: 1'b1});
            wait_grant(g);
            @(posedge clk);
            #1;
            req_valid = '0;
            if (n == 0) begin
                wait_rsp();
                chk("rsp_err_first", 32'(rsp_err), 1);
            end
            drain();
            if (n == 0) chk("err_cnt_one", 32'(err_cnt), 1);
        end
        chk("err_cnt_saturated", 32'(err_cnt), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
